// File: rtl/execute_br_dest_pipe_pkg.sv
// execute_br_dest_pipe_pkg
//   Shared definitions for the execute-stage branch-destination pipe:
//   default register width, branch-destination op encodings and the
//   buffer state encoding.
package execute_br_dest_pipe_pkg;

    localparam int REGSZ = 32;

    // Branch-destination op field (3 bits; 5-7 are illegal).
    typedef enum logic [2:0] {
        EXOP_BR_DEST_NONE    = 3'd0,
        EXOP_BR_DEST_A       = 3'd1,
        EXOP_BR_DEST_C       = 3'd2,
        EXOP_BR_DEST_PC_A_AA = 3'd3,
        EXOP_BR_DEST_PC_C_AA = 3'd4
    } br_dest_op_e;

    // Occupancy of the MAIN + SKID output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/execute_br_dest_pipe_br_dest_calc.sv
// br_dest_calc
//   Combinational branch-target / link-address computation.
//   Ports:
//     i_op, i_aa, i_lk        : op code, absolute-address bit, link request
//     i_op_a, i_op_c, i_pc    : operand A, operand C, branch PC
//     o_dest                  : aligned target (low ALIGN_BITS always 0)
//     o_link_valid, o_link_addr : link flag and pc + INST_BYTES
//     o_bad_op                : op code is illegal
module br_dest_calc
    import execute_br_dest_pipe_pkg::*;
#(
    parameter int WIDTH      = REGSZ,
    parameter int ALIGN_BITS = 2,
    parameter int INST_BYTES = 4
) (
    input  logic [2:0]       i_op,
    input  logic             i_aa,
    input  logic             i_lk,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_c,
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_dest,
    output logic             o_link_valid,
    output logic [WIDTH-1:0] o_link_addr,
    output logic             o_bad_op
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));
    localparam logic [WIDTH-1:0] LINK_INC   = WIDTH'(INST_BYTES);

    logic [WIDTH-1:0] w_a_m;
    logic [WIDTH-1:0] w_c_m;
    logic [WIDTH-1:0] w_pc_m;

    assign w_a_m  = i_op_a & ALIGN_MASK;
    assign w_c_m  = i_op_c & ALIGN_MASK;
    assign w_pc_m = i_pc   & ALIGN_MASK;

    // Adding two masked values keeps the low bits zero, so a full-width add
    // wraps exactly like a sum over the upper bits alone.
    always_comb begin
        o_dest   = '0;
        o_bad_op = 1'b0;
        case (i_op)
            EXOP_BR_DEST_NONE:    o_dest = '0;
            EXOP_BR_DEST_A:       o_dest = w_a_m;
            EXOP_BR_DEST_C:       o_dest = w_c_m;
            EXOP_BR_DEST_PC_A_AA: o_dest = i_aa ? w_a_m : w_a_m + w_pc_m;
            EXOP_BR_DEST_PC_C_AA: o_dest = i_aa ? w_c_m : w_c_m + w_pc_m;
            default:              o_bad_op = 1'b1;
        endcase
    end

    assign o_link_valid = i_lk && !o_bad_op;
    assign o_link_addr  = o_link_valid ? i_pc + LINK_INC : '0;

endmodule

// File: rtl/execute_br_dest_pipe.sv
// execute_br_dest_pipe
//   Registered branch-destination unit with a two-entry (MAIN + SKID)
//   output buffer so the redirect path is retimed and back-pressurable.
//   Ports:
//     clk, reset                 : clock, async active-high reset
//     in_valid / in_ready        : request handshake (in_ready is registered)
//     brdest_op, inst_aa, inst_lk, op_a, op_c, pc : request fields
//     flush                      : drop all held and same-cycle results
//     out_valid / out_ready      : result handshake
//     br_dest, link_valid, link_addr, bad_op : result fields (from MAIN)
//     err_sticky                 : an illegal op was accepted since reset
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held, outputs invalid
//   ST_ONE   | MAIN holds a result, SKID free
//   ST_TWO   | MAIN and SKID hold results, input stalled
module execute_br_dest_pipe
    import execute_br_dest_pipe_pkg::*;
#(
    parameter int WIDTH      = REGSZ,
    parameter int ALIGN_BITS = 2,
    parameter int INST_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       brdest_op,
    input  logic             inst_aa,
    input  logic             inst_lk,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_c,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] br_dest,
    output logic             link_valid,
    output logic [WIDTH-1:0] link_addr,
    output logic             bad_op,
    output logic             err_sticky
);

    pipe_state_e r_state;
    pipe_state_e w_state_next;

    logic             r_in_ready;
    logic             r_err_sticky;

    logic [WIDTH-1:0] r_main_dest;
    logic             r_main_lv;
    logic [WIDTH-1:0] r_main_la;
    logic             r_main_bad;

    logic [WIDTH-1:0] r_skid_dest;
    logic             r_skid_lv;
    logic [WIDTH-1:0] r_skid_la;
    logic             r_skid_bad;

    logic [WIDTH-1:0] w_calc_dest;
    logic             w_calc_lv;
    logic [WIDTH-1:0] w_calc_la;
    logic             w_calc_bad;

    logic             w_fire_in;
    logic             w_fire_out;
    logic             w_accept;
    logic             w_load_main_new;
    logic             w_load_main_skid;
    logic             w_load_skid;

    br_dest_calc #(
        .WIDTH      (WIDTH),
        .ALIGN_BITS (ALIGN_BITS),
        .INST_BYTES (INST_BYTES)
    ) u_calc (
        .i_op         (brdest_op),
        .i_aa         (inst_aa),
        .i_lk         (inst_lk),
        .i_op_a       (op_a),
        .i_op_c       (op_c),
        .i_pc         (pc),
        .o_dest       (w_calc_dest),
        .o_link_valid (w_calc_lv),
        .o_link_addr  (w_calc_la),
        .o_bad_op     (w_calc_bad)
    );

    assign out_valid  = (r_state != ST_EMPTY);
    assign in_ready   = r_in_ready;
    assign w_fire_in  = in_valid && r_in_ready;
    assign w_fire_out = out_valid && out_ready;
    // A request that coincides with flush is discarded entirely.
    assign w_accept   = w_fire_in && !flush;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_fire_in) begin
                        w_state_next    = ST_ONE;
                        w_load_main_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_fire_in && w_fire_out) begin
                        w_load_main_new = 1'b1;
                    end else if (w_fire_in) begin
                        w_state_next = ST_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_fire_out) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_fire_out) begin
                        w_state_next     = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            r_err_sticky <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            // in_ready mirrors "SKID not full" for the coming cycle.
            r_in_ready <= (w_state_next != ST_TWO);
            if (w_accept && w_calc_bad) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_dest <= '0;
            r_main_lv   <= 1'b0;
            r_main_la   <= '0;
            r_main_bad  <= 1'b0;
            r_skid_dest <= '0;
            r_skid_lv   <= 1'b0;
            r_skid_la   <= '0;
            r_skid_bad  <= 1'b0;
        end else begin
            if (w_load_main_new) begin
                r_main_dest <= w_calc_dest;
                r_main_lv   <= w_calc_lv;
                r_main_la   <= w_calc_la;
                r_main_bad  <= w_calc_bad;
            end else if (w_load_main_skid) begin
                r_main_dest <= r_skid_dest;
                r_main_lv   <= r_skid_lv;
                r_main_la   <= r_skid_la;
                r_main_bad  <= r_skid_bad;
            end
            if (w_load_skid) begin
                r_skid_dest <= w_calc_dest;
                r_skid_lv   <= w_calc_lv;
                r_skid_la   <= w_calc_la;
                r_skid_bad  <= w_calc_bad;
            end
        end
    end

`ifdef SIM
    always_ff @(posedge clk) begin
        if (!reset && w_accept && w_calc_bad) begin
            $fatal(1, "execute_br_dest_pipe: illegal brdest_op %0d accepted", brdest_op);
        end
    end
`endif

    assign br_dest    = r_main_dest;
    assign link_valid = r_main_lv;
    assign link_addr  = r_main_la;
    assign bad_op     = r_main_bad;
    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_execute_br_dest_pipe.sv
module tb_execute_br_dest_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  brdest_op;
    logic        inst_aa;
    logic        inst_lk;
    logic [31:0] op_a;
    logic [31:0] op_c;
    logic [31:0] pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] br_dest;
    logic        link_valid;
    logic [31:0] link_addr;
    logic        bad_op;
    logic        err_sticky;

    int n_cmp = 0;
    int n_mis = 0;

    execute_br_dest_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .brdest_op  (brdest_op),
        .inst_aa    (inst_aa),
        .inst_lk    (inst_lk),
        .op_a       (op_a),
        .op_c       (op_c),
        .pc         (pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .br_dest    (br_dest),
        .link_valid (link_valid),
        .link_addr  (link_addr),
        .bad_op     (bad_op),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic aa, input logic lk,
                         input logic [31:0] a, input logic [31:0] c, input logic [31:0] p);
        in_valid  = v;
        brdest_op = op;
        inst_aa   = aa;
        inst_lk   = lk;
        op_a      = a;
        op_c      = c;
        pc        = p;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0)   begin n_mis++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)    begin n_mis++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (br_dest !== 32'h0)    begin n_mis++; $display("FAIL reset_br_dest got %h want 0", br_dest); end
        n_cmp++; if ({link_valid, bad_op, err_sticky} !== 3'b000)
                                           begin n_mis++; $display("FAIL reset_flags got %b want 000", {link_valid, bad_op, err_sticky}); end
        n_cmp++; if (link_addr !== 32'h0)  begin n_mis++; $display("FAIL reset_link_addr got %h want 0", link_addr); end
        #3 reset = 1'b0;
        tick();
    endtask

    task automatic test_pc_relative();
        out_ready = 1'b1;
        drive(1'b1, 3'd3, 1'b0, 1'b0, 32'h0000_0107, 32'h0, 32'h0000_1000);
        tick();
        n_cmp++; if (out_valid !== 1'b1)        begin n_mis++; $display("FAIL pcrel_valid got %b want 1", out_valid); end
        n_cmp++; if (br_dest !== 32'h0000_1104) begin n_mis++; $display("FAIL pcrel_dest got %h want 00001104", br_dest); end
        drive(1'b1, 3'd3, 1'b1, 1'b0, 32'hFFFF_FFF7, 32'h0, 32'h0000_1000);
        tick();
        n_cmp++; if (br_dest !== 32'hFFFF_FFF4) begin n_mis++; $display("FAIL abs_dest got %h want fffffff4", br_dest); end
        n_cmp++; if (link_valid !== 1'b0)       begin n_mis++; $display("FAIL abs_link_valid got %b want 0", link_valid); end
        drive(1'b1, 3'd4, 1'b0, 1'b1, 32'h0, 32'h0000_0020, 32'hFFFF_FFF0);
        tick();
        n_cmp++; if (br_dest !== 32'h0000_0010) begin n_mis++; $display("FAIL wrap_dest got %h want 00000010", br_dest); end
        n_cmp++; if (link_valid !== 1'b1)       begin n_mis++; $display("FAIL wrap_link_valid got %b want 1", link_valid); end
        n_cmp++; if (link_addr !== 32'hFFFF_FFF4) begin n_mis++; $display("FAIL wrap_link_addr got %h want fffffff4", link_addr); end
        drive(1'b1, 3'd2, 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h0000_1237, 32'h0000_2000);
        tick();
        n_cmp++; if (br_dest !== 32'h0000_1234) begin n_mis++; $display("FAIL destc_dest got %h want 00001234", br_dest); end
        n_cmp++; if (link_addr !== 32'h0)       begin n_mis++; $display("FAIL destc_link_addr got %h want 0", link_addr); end
        drive(1'b1, 3'd0, 1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h0000_3000);
        tick();
        n_cmp++; if (br_dest !== 32'h0)         begin n_mis++; $display("FAIL none_dest got %h want 0", br_dest); end
        n_cmp++; if (link_addr !== 32'h0000_3004) begin n_mis++; $display("FAIL none_link_addr got %h want 00003004", link_addr); end
        drive(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        n_cmp++; if (out_valid !== 1'b0)        begin n_mis++; $display("FAIL pcrel_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
        tick();
        n_cmp++; if (in_ready !== 1'b1 || br_dest !== 32'h100)
            begin n_mis++; $display("FAIL bp_first got rdy=%b dest=%h want rdy=1 dest=100", in_ready, br_dest); end
        op_a = 32'h200;
        tick();
        n_cmp++; if (in_ready !== 1'b0 || br_dest !== 32'h100)
            begin n_mis++; $display("FAIL bp_second got rdy=%b dest=%h want rdy=0 dest=100", in_ready, br_dest); end
        op_a = 32'h300;
        tick();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || br_dest !== 32'h100)
            begin n_mis++; $display("FAIL bp_stall got rdy=%b v=%b dest=%h want rdy=0 v=1 dest=100", in_ready, out_valid, br_dest); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (br_dest !== 32'h200 || in_ready !== 1'b1)
            begin n_mis++; $display("FAIL bp_out2 got dest=%h rdy=%b want dest=200 rdy=1", br_dest, in_ready); end
        tick();
        n_cmp++; if (br_dest !== 32'h300 || out_valid !== 1'b1)
            begin n_mis++; $display("FAIL bp_out3 got dest=%h v=%b want dest=300 v=1", br_dest, out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || br_dest !== 32'h300)
            begin n_mis++; $display("FAIL bp_drain got v=%b dest=%h want v=0 dest=300 held", out_valid, br_dest); end
    endtask

    task automatic test_illegal_sticky();
        out_ready = 1'b1;
        drive(1'b1, 3'd6, 1'b0, 1'b1, 32'h0000_5555, 32'h0, 32'h0000_4000);
        tick();
        n_cmp++; if (bad_op !== 1'b1 || br_dest !== 32'h0 || err_sticky !== 1'b1 || link_valid !== 1'b0)
            begin n_mis++; $display("FAIL illegal got bad=%b dest=%h err=%b lv=%b want 1 0 1 0", bad_op, br_dest, err_sticky, link_valid); end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || err_sticky !== 1'b1)
            begin n_mis++; $display("FAIL illegal_flush got v=%b err=%b want v=0 err=1", out_valid, err_sticky); end
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 3'd1, 1'b0, 1'b0, 32'(i * 16 + 3), 32'h0, 32'h0);
            tick();
            n_cmp++; if (br_dest !== 32'(i * 16) || bad_op !== 1'b0)
                begin n_mis++; $display("FAIL good_op_%0d got dest=%h bad=%b want dest=%h bad=0", i, br_dest, bad_op, 32'(i * 16)); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (err_sticky !== 1'b1) begin n_mis++; $display("FAIL sticky_persist got %b want 1", err_sticky); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0);
        tick();
        op_a = 32'h500;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_mis++; $display("FAIL flush_setup_two got rdy=%b want 0", in_ready); end
        op_a = 32'h600;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_mis++; $display("FAIL flush_two got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_ghost_%0d got v=%b want 0", i, out_valid); end
        end
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h700, 32'h0, 32'h0);
        out_ready = 1'b0;
        tick();
        op_a = 32'h800;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_one_drop got v=%b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h0);
        tick();
        op_a = 32'hA00;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || err_sticky !== 1'b1)
            begin n_mis++; $display("FAIL areset_setup got v=%b rdy=%b err=%b want 1 0 1", out_valid, in_ready, err_sticky); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || br_dest !== 32'h0 || err_sticky !== 1'b0 || in_ready !== 1'b1)
            begin n_mis++; $display("FAIL areset_immediate got v=%b dest=%h err=%b rdy=%b want 0 0 0 1", out_valid, br_dest, err_sticky, in_ready); end
        #3 reset = 1'b0;
        tick();
        out_ready = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'hB00, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || br_dest !== 32'hB00)
            begin n_mis++; $display("FAIL areset_latency got v=%b dest=%h want v=1 dest=b00", out_valid, br_dest); end
        tick();
    endtask

    initial begin
        test_reset();
        test_pc_relative();
        test_back_pressure();
        test_illegal_sticky();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
